// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Used by alu_arbiter and its bench; optional NZCV register is enabled with ALU_ARB_FLAGS_EN.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, and a tie goes to whoever
// did not win last time. Purely combinational; enable low forces no grant.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // one-hot grant selection
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_FLAGS_EN to keep an architectural NZCV register in flags_q.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b1,
    input  logic [1:0]        req_ctrl0,
    input  logic [1:0]        req_ctrl1,
    input  logic [1:0]        req_setflags,
    output logic [WIDTH-1:0]  alu_srca,
    output logic [WIDTH-1:0]  alu_srcb,
    output logic [1:0]        alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [FLAG_W-1:0] flags_q
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [1:0]        op_ctrl_q, op_ctrl_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [1:0]        grant_s;
    logic              arb_en_s;

    // Gate with reset_n so nothing is offered while reset is held.
    assign arb_en_s = (state_q == IDLE) && reset_n;

    rr_arbiter2 u_rr (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en_s),
        .grant      (grant_s)
    );

    assign req_ready  = grant_s;
    assign alu_srca   = op_a_q;
    assign alu_srcb   = op_b_q;
    assign alu_ctrl   = op_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (grant_s != 2'b00) ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: latch on accept, capture at end of EXEC, release on rsp_ready
    always_comb begin
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    id_d         = grant_s[1];
                    last_grant_d = grant_s[1];
                    op_a_d       = grant_s[1] ? req_a1 : req_a0;
                    op_b_d       = grant_s[1] ? req_b1 : req_b0;
                    op_ctrl_d    = grant_s[1] ? req_ctrl1 : req_ctrl0;
                end else begin
                    id_d = id_q;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flag;
                rsp_valid_d  = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: rsp_valid_d = 1'b0;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_a_q       <= {WIDTH{1'b0}};
            op_b_q       <= {WIDTH{1'b0}};
            op_ctrl_q    <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_flags_q  <= {FLAG_W{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic              op_setflags_q, op_setflags_d;
    logic [FLAG_W-1:0] flags_d;

    // setflags is latched with the operands; NZCV updates only for qualified ops
    always_comb begin
        op_setflags_d = op_setflags_q;
        flags_d       = flags_q;
        if ((state_q == IDLE) && (grant_s != 2'b00)) begin
            op_setflags_d = grant_s[1] ? req_setflags[1] : req_setflags[0];
        end else if ((state_q == EXEC) && op_setflags_q) begin
            flags_d = alu_flag;
        end else begin
            flags_d = flags_q;
        end
    end

    // architectural flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_setflags_q <= 1'b0;
            flags_q       <= {FLAG_W{1'b0}};
        end else begin
            op_setflags_q <= op_setflags_d;
            flags_q       <= flags_d;
        end
    end
`else
    logic unused_setflags_s;
    assign unused_setflags_s = ^req_setflags;
    assign flags_q = {FLAG_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 32-bit ALU attached.
// Expectations for flags_q follow ALU_ARB_FLAGS_EN.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_ctrl0, req_ctrl1;
    logic [1:0]  req_setflags;
    logic [31:0] alu_srca, alu_srcb;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags_q;

    int checks = 0;
    int errors = 0;

`ifdef ALU_ARB_FLAGS_EN
    localparam logic [3:0] EXP_FQ = 4'b0110;
`else
    localparam logic [3:0] EXP_FQ = 4'b0000;
`endif

    alu_arbiter #(.WIDTH(32), .FLAG_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a0       (req_a0),
        .req_b0       (req_b0),
        .req_a1       (req_a1),
        .req_b1       (req_b1),
        .req_ctrl0    (req_ctrl0),
        .req_ctrl1    (req_ctrl1),
        .req_setflags (req_setflags),
        .alu_srca     (alu_srca),
        .alu_srcb     (alu_srcb),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_flag     (alu_flag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .flags_q      (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external ALU: ADD/SUB produce carry (no-borrow for SUB) and overflow, logic ops clear C/V
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = 33'd0;
        case (alu_ctrl)
            ALU_ADD: alu_sum = {1'b0, alu_srca} + {1'b0, alu_srcb};
            ALU_SUB: alu_sum = {1'b0, alu_srca} + {1'b0, ~alu_srcb} + 33'd1;
            ALU_AND: alu_sum = {1'b0, alu_srca & alu_srcb};
            default: alu_sum = {1'b0, alu_srca | alu_srcb};
        endcase
        alu_result       = alu_sum[31:0];
        alu_flag         = 4'b0000;
        alu_flag[FLAG_N] = alu_sum[31];
        alu_flag[FLAG_Z] = (alu_sum[31:0] == 32'd0);
        alu_flag[FLAG_C] = alu_ctrl[1] ? 1'b0 : alu_sum[32];
        if (alu_ctrl == ALU_ADD)
            alu_flag[FLAG_V] = (alu_srca[31] == alu_srcb[31]) && (alu_sum[31] != alu_srca[31]);
        else if (alu_ctrl == ALU_SUB)
            alu_flag[FLAG_V] = (alu_srca[31] != alu_srcb[31]) && (alu_sum[31] != alu_srca[31]);
        else
            alu_flag[FLAG_V] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid    = 2'b00;
        req_a0       = 32'd0;
        req_b0       = 32'd0;
        req_a1       = 32'd0;
        req_b1       = 32'd0;
        req_ctrl0    = 2'b00;
        req_ctrl1    = 2'b00;
        req_setflags = 2'b00;
        rsp_ready    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // single-requester operation from IDLE; returns to IDLE at a negedge
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctrl, input logic sf,
                         input logic [31:0] er, input logic [3:0] ef, input logic [3:0] efq);
        req_valid    = id ? 2'b10 : 2'b01;
        req_setflags = id ? {sf, 1'b0} : {1'b0, sf};
        if (id) begin
            req_a1 = a; req_b1 = b; req_ctrl1 = ctrl;
        end else begin
            req_a0 = a; req_b0 = b; req_ctrl0 = ctrl;
        end
        rsp_ready = 1'b1;
        #1;
        check("idle_req_ready", {30'd0, req_ready}, id ? 32'd2 : 32'd1);
        tick();
        req_valid = 2'b00;
        check("exec_srca", alu_srca, a);
        check("exec_srcb", alu_srcb, b);
        check("exec_ctrl", {30'd0, alu_ctrl}, {30'd0, ctrl});
        check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("resp_valid", {31'd0, rsp_valid}, 32'd1);
        check("resp_id", {31'd0, rsp_id}, {31'd0, id});
        check("resp_result", rsp_result, er);
        check("resp_flags", {28'd0, rsp_flags}, {28'd0, ef});
        check("resp_flags_q", {28'd0, flags_q}, {28'd0, efq});
        check("resp_req_ready", {30'd0, req_ready}, 32'd0);
        tick();
        check("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] k0;
        logic [31:0] k1;
        logic [31:0] exp_r;

        vecs[0] = '{1'b0, 32'd5,          32'd3,          ALU_ADD, 32'd8,          4'b0000};
        vecs[1] = '{1'b1, 32'd3,          32'd5,          ALU_SUB, 32'hFFFF_FFFE,  4'b1000};
        vecs[2] = '{1'b0, 32'hF0F0_F0F0,  32'hFF00_FF00,  ALU_AND, 32'hF000_F000,  4'b1000};
        vecs[3] = '{1'b1, 32'd0,          32'd0,          ALU_ORR, 32'd0,          4'b0100};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          ALU_ADD, 32'd0,          4'b0110};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  4'b1001};
        vecs[6] = '{1'b0, 32'd5,          32'd5,          ALU_SUB, 32'd0,          4'b0110};
        vecs[7] = '{1'b1, 32'h8000_0000,  32'd1,          ALU_SUB, 32'h7FFF_FFFF,  4'b0011};

        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        req_valid = 2'b11;
        tick();
        tick();
        #1;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_srca", alu_srca, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags_q", {28'd0, flags_q}, 32'd0);
        req_valid = 2'b00;
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ctrl, 1'b0,
                  vecs[i].res, vecs[i].flg, 4'b0000);
        end

        // both requesters continuously valid: strict alternation starting with 0
        do_reset();
        k0 = 32'd0;
        k1 = 32'd0;
        for (int n = 0; n < 8; n++) begin
            req_valid = 2'b11;
            req_a0 = 32'd10 + k0; req_b0 = 32'd1; req_ctrl0 = ALU_ADD;
            req_a1 = 32'd20 + k1; req_b1 = 32'd2; req_ctrl1 = ALU_ADD;
            rsp_ready = 1'b1;
            exp_r = (n % 2 == 1) ? (32'd22 + k1) : (32'd11 + k0);
            #1;
            check("rr_grant", {30'd0, req_ready}, (n % 2 == 1) ? 32'd2 : 32'd1);
            tick();
            if (n % 2 == 1) k1 = k1 + 32'd1;
            else            k0 = k0 + 32'd1;
            tick();
            check("rr_rsp_id", {31'd0, rsp_id}, (n % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_result", rsp_result, exp_r);
            tick();
        end
        idle_inputs();

        // backpressure in RESP, then the other requester wins
        req_valid = 2'b11;
        req_a0 = 32'd100; req_b0 = 32'd1; req_ctrl0 = ALU_ADD;
        req_a1 = 32'd200; req_b1 = 32'd1; req_ctrl1 = ALU_ADD;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant0", {30'd0, req_ready}, 32'd1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_result", rsp_result, 32'd101);
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            if (c < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_grant1", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check("bp2_id", {31'd0, rsp_id}, 32'd1);
        check("bp2_result", rsp_result, 32'd201);
        tick();
        check("bp2_done", {31'd0, rsp_valid}, 32'd0);
        idle_inputs();

        // reset during EXEC drops the op
        req_valid = 2'b01;
        req_a0 = 32'd9; req_b0 = 32'd7; req_ctrl0 = ALU_SUB;
        tick();
        req_valid = 2'b00;
        check("rx_exec_srca", alu_srca, 32'd9);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rx_srca", alu_srca, 32'd0);
        check("rx_srcb", alu_srcb, 32'd0);
        check("rx_ctrl", {30'd0, alu_ctrl}, 32'd0);
        check("rx_result", rsp_result, 32'd0);
        check("rx_flags", {28'd0, rsp_flags}, 32'd0);
        check("rx_id", {31'd0, rsp_id}, 32'd0);
        check("rx_req_ready", {30'd0, req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_op(1'b0, 32'd5, 32'd3, ALU_ADD, 1'b0, 32'd8, 4'b0000, 4'b0000);

        // setflags qualifier on the optional NZCV register
        do_op(1'b0, 32'd5, 32'd5, ALU_SUB, 1'b1, 32'd0, 4'b0110, EXP_FQ);
        do_op(1'b0, 32'd1, 32'd1, ALU_ADD, 1'b0, 32'd2, 4'b0000, EXP_FQ);
        tick();
        check("final_flags_q", {28'd0, flags_q}, {28'd0, EXP_FQ});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
